// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
// Shared definitions for the sequential restoring divider.
//   state_t   : FSM encoding (S_IDLE, S_CALC)
//   cnt_width : width of the iteration counter for a given operand width
// -----------------------------------------------------------------------------
package divider_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CALC = 1'b1
  } state_t;

  // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice
  // (WIDTH >= 2 keeps this at least one bit).
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//   rem      in  [WIDTH:0]   partial remainder before the shift
//   next_bit in              dividend bit shifted into the remainder LSB
//   divisor  in  [WIDTH-1:0] denominator
//   rem_next out [WIDTH:0]   partial remainder after the trial subtraction
//   q_bit    out             quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             borrow;

  // One extra bit above the shifted remainder so the sign of the trial
  // subtraction is the borrow out.
  assign shifted  = {rem, next_bit};
  assign trial    = shifted - {2'b00, divisor};
  assign borrow   = trial[WIDTH+1];

  assign q_bit    = ~borrow;
  assign rem_next = borrow ? shifted[WIDTH:0] : trial[WIDTH:0];

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle unsigned restoring divider: one quotient bit per clock.
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset
//   start       in   request pulse, sampled only while idle
//   dividend    in   [WIDTH-1:0] numerator, sampled on the accepting edge
//   divisor     in   [WIDTH-1:0] denominator, sampled on the accepting edge
//   busy        out  high while a division is in progress
//   done        out  one-cycle pulse; results valid from this cycle onward
//   quotient    out  [WIDTH-1:0] held until the next done
//   remainder   out  [WIDTH-1:0] held until the next done
//   div_by_zero out  flag for the last completed operation
//   dbg_state   out  current FSM state (1 = S_CALC)
//
// Handshake: a request is accepted on any rising edge where start=1 and the
// block is idle (busy=0 and no divide-by-zero result pending); start at any
// other time is dropped, never queued. Exactly one done pulse follows each
// accepted request unless rst intervenes. Because done is raised as the FSM
// returns to S_IDLE, a start held during the done cycle is accepted.
// -----------------------------------------------------------------------------
module seq_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             dbg_state
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;     // dividend bits shift out, quotient bits shift in
  logic             dz_pend;   // zero-divisor result is reported one edge later

  logic [WIDTH:0]   step_rem;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .next_bit (quo_q[WIDTH-1]),
    .divisor  (dvsr),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  assign dbg_state = (state == S_CALC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      dvsr        <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dz_pend     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dz_pend) begin
            // quo_q still holds the dividend captured on the accepting edge.
            dz_pend     <= 1'b0;
            quotient    <= '1;
            remainder   <= quo_q;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
          end else if (start) begin
            quo_q <= dividend;
            if (divisor != '0) begin
              dvsr  <= divisor;
              rem_q <= '0;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= S_CALC;
            end else begin
              dz_pend <= 1'b1;
            end
          end
        end
        S_CALC: begin
          rem_q <= step_rem;
          quo_q <= {quo_q[WIDTH-2:0], step_q};
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            quotient    <= {quo_q[WIDTH-2:0], step_q};
            remainder   <= step_rem[WIDTH-1:0];
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Directed scenarios for seq_divider (WIDTH=32) with hand-computed results.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         dbg_state;

  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // ---------------- driver tasks ----------------
  // Present a request and step past the accepting edge; returns #1 after it.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  // Count edges until done is seen (bounded) and the cycles with busy high.
  task automatic wait_done(output int n, output int busy_n);
    n = 0;
    busy_n = 0;
    while (done !== 1'b1 && n < 100) begin
      if (busy === 1'b1) busy_n++;
      @(posedge clk); #1;
      n++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (quotient !== '0) begin errors++; $display("FAIL reset_quotient: got %h expected 0", quotient); end
    checks++; if (remainder !== '0) begin errors++; $display("FAIL reset_remainder: got %h expected 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %b expected 0", dbg_state); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int n, bn;
    issue(32'd100, 32'd7);
    checks++; if (dbg_state !== 1'b1) begin errors++; $display("FAIL basic_state_calc: got %b expected 1", dbg_state); end
    wait_done(n, bn);
    checks++; if (n !== 32) begin errors++; $display("FAIL basic_latency: got %0d expected 32", n); end
    checks++; if (bn !== 32) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 32", bn); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_on_done: got %b expected 0", busy); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL basic_quotient: got %0d expected 14", quotient); end
    checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL basic_remainder: got %0d expected 2", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz: got %b expected 0", div_by_zero); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL basic_hold: got %0d expected 14", quotient); end
  endtask

  task automatic test_extremes();
    int n, bn;
    issue(32'hFFFF_FFFF, 32'd1);
    wait_done(n, bn);
    checks++; if (quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL max_quotient: got %h expected ffffffff", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL max_remainder: got %h expected 0", remainder); end
    @(posedge clk); #1;
    issue(32'd5, 32'd9);
    wait_done(n, bn);
    checks++; if (n !== 32) begin errors++; $display("FAIL small_latency: got %0d expected 32", n); end
    checks++; if (quotient !== 32'd0) begin errors++; $display("FAIL small_quotient: got %0d expected 0", quotient); end
    checks++; if (remainder !== 32'd5) begin errors++; $display("FAIL small_remainder: got %0d expected 5", remainder); end
    @(posedge clk); #1;
    // Largest dividend over largest divisor and a near-equal pair.
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n, bn);
    checks++; if (quotient !== 32'd1 || remainder !== 32'd0) begin errors++; $display("FAIL maxmax: got q=%h r=%h expected q=1 r=0", quotient, remainder); end
    @(posedge clk); #1;
    issue(32'hFFFF_FFFE, 32'hFFFF_FFFF);
    wait_done(n, bn);
    checks++; if (quotient !== 32'd0 || remainder !== 32'hFFFF_FFFE) begin errors++; $display("FAIL near_max: got q=%h r=%h expected q=0 r=fffffffe", quotient, remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero();
    int n, bn;
    issue(32'd123, 32'd0);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL dz_after_accept: got busy=%b done=%b expected 0 0", busy, done); end
    wait_done(n, bn);
    checks++; if (n !== 1) begin errors++; $display("FAIL dz_latency: got %0d expected 1", n); end
    checks++; if (bn !== 0 || busy !== 1'b0) begin errors++; $display("FAIL dz_busy: got %0d cycles expected 0", bn); end
    checks++; if (quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_quotient: got %h expected ffffffff", quotient); end
    checks++; if (remainder !== 32'd123) begin errors++; $display("FAIL dz_remainder: got %0d expected 123", remainder); end
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b expected 1", div_by_zero); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_hold: got done=%b flag=%b expected 0 1", done, div_by_zero); end
  endtask

  task automatic test_ignore_start();
    int n, bn, dones;
    issue(32'd50, 32'd5);
    repeat (10) begin @(posedge clk); #1; end
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    wait_done(n, bn);
    checks++; if (n + 11 !== 32) begin errors++; $display("FAIL ign_latency: got %0d expected 32", n + 11); end
    checks++; if (quotient !== 32'd10 || remainder !== 32'd0) begin errors++; $display("FAIL ign_result: got q=%0d r=%0d expected q=10 r=0", quotient, remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL ign_dbz_clear: got %b expected 0", div_by_zero); end
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL ign_extra_done: got %0d active cycles expected 0", dones); end
  endtask

  task automatic test_back_to_back();
    int n, bn, n2;
    issue(32'd100, 32'd7);
    wait_done(n, bn);
    checks++; if (quotient !== 32'd14 || remainder !== 32'd2) begin errors++; $display("FAIL b2b_first: got q=%0d r=%0d expected q=14 r=2", quotient, remainder); end
    issue(32'd1000, 32'd3);  // presented during the done cycle
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b expected 1", busy); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL b2b_held: got %0d expected 14", quotient); end
    wait_done(n2, bn);
    checks++; if (n2 !== 32) begin errors++; $display("FAIL b2b_latency: got %0d expected 32", n2); end
    checks++; if (n2 + 1 !== W + 1) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d", n2 + 1, W + 1); end
    checks++; if (quotient !== 32'd333 || remainder !== 32'd1) begin errors++; $display("FAIL b2b_second: got q=%0d r=%0d expected q=333 r=1", quotient, remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int n, bn, act;
    issue(32'd77, 32'd4);
    repeat (14) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || dbg_state !== 1'b0) begin errors++; $display("FAIL rmid_ctrl: got busy=%b done=%b state=%b expected 0 0 0", busy, done, dbg_state); end
    checks++; if (quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin errors++; $display("FAIL rmid_outputs: got q=%h r=%h dbz=%b expected 0 0 0", quotient, remainder, div_by_zero); end
    @(posedge clk); #1;
    rst = 1'b1;
    act = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) act++;
    end
    checks++; if (act !== 0) begin errors++; $display("FAIL rmid_no_done: got %0d active cycles expected 0", act); end
    issue(32'd77, 32'd4);
    wait_done(n, bn);
    checks++; if (n !== 32) begin errors++; $display("FAIL rmid_latency: got %0d expected 32", n); end
    checks++; if (quotient !== 32'd19 || remainder !== 32'd1) begin errors++; $display("FAIL rmid_fresh: got q=%0d r=%0d expected q=19 r=1", quotient, remainder); end
    @(posedge clk); #1;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
